// File: rtl/exe_operand_stage.sv
// EXE pipeline stage: latches one decoded instruction from ID, builds the two ALU
// operands, collects the ALU result/overflow for MEM and drives the ID bypass bus.
module exe_operand_stage #(
  parameter int DW  = 32,
  parameter int OPW = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           ds_to_es_valid,
  output logic           es_allowin,
  input  logic [31:0]    ds_pc,
  input  logic [OPW-1:0] ds_aluop,
  input  logic [DW-1:0]  ds_rs_val,
  input  logic [DW-1:0]  ds_rt_val,
  input  logic [15:0]    ds_imm,
  input  logic [4:0]     ds_sa,
  input  logic           ds_src1_sa,
  input  logic           ds_src2_imm,
  input  logic           ds_imm_zext,
  input  logic           ds_ov_en,
  input  logic           ds_rf_we,
  input  logic [4:0]     ds_dest,
  output logic [DW-1:0]  alu_scr0,
  output logic [DW-1:0]  alu_scr1,
  output logic [OPW-1:0] alu_aluop,
  input  logic [DW-1:0]  alu_aluso,
  input  logic           alu_overflow,
  input  logic           ms_allowin,
  output logic           es_to_ms_valid,
  output logic [31:0]    es_pc,
  output logic [DW-1:0]  es_result,
  output logic [4:0]     es_dest,
  output logic           es_rf_we,
  output logic           es_ex_ov,
  output logic           es_fwd_we,
  output logic [4:0]     es_fwd_dest,
  output logic [DW-1:0]  es_fwd_data
);

  typedef struct packed {
    logic [31:0]    pc;
    logic [OPW-1:0] aluop;
    logic [DW-1:0]  rs_val;
    logic [DW-1:0]  rt_val;
    logic [15:0]    imm;
    logic [4:0]     sa;
    logic           src1_sa;
    logic           src2_imm;
    logic           imm_zext;
    logic           ov_en;
    logic           rf_we;
    logic [4:0]     dest;
  } es_fields_t;

  logic       es_valid_q, es_valid_d;
  logic       ex_pending_q, ex_pending_d;
  es_fields_t fld_q, fld_d;
  logic [DW-1:0] imm_ext;

  // Single-cycle stage: ready_go is always 1.
  assign es_allowin     = !es_valid_q || ms_allowin;
  assign es_to_ms_valid = es_valid_q && !flush;

  assign imm_ext   = fld_q.imm_zext ? {{(DW-16){1'b0}}, fld_q.imm}
                                    : {{(DW-16){fld_q.imm[15]}}, fld_q.imm};
  assign alu_scr0  = fld_q.src1_sa  ? {{(DW-5){1'b0}}, fld_q.sa} : fld_q.rs_val;
  assign alu_scr1  = fld_q.src2_imm ? imm_ext : fld_q.rt_val;
  assign alu_aluop = es_valid_q ? fld_q.aluop : '0;

  // Once an overflow has been handed to MEM, younger instructions are neutered.
  assign es_ex_ov  = es_valid_q && fld_q.ov_en && alu_overflow && !ex_pending_q;
  assign es_rf_we  = es_valid_q && fld_q.rf_we && !es_ex_ov && !ex_pending_q;

  assign es_pc       = fld_q.pc;
  assign es_dest     = fld_q.dest;
  assign es_result   = alu_aluso;
  assign es_fwd_we   = es_rf_we && (fld_q.dest != 5'd0);
  assign es_fwd_dest = fld_q.dest;
  assign es_fwd_data = alu_aluso;

  always_comb begin
    es_valid_d   = es_valid_q;
    ex_pending_d = ex_pending_q;
    fld_d        = fld_q;
    if (flush) begin
      es_valid_d   = 1'b0;
      ex_pending_d = 1'b0;
    end else begin
      if (es_ex_ov && es_to_ms_valid && ms_allowin) ex_pending_d = 1'b1;
      if (es_allowin) begin
        es_valid_d = ds_to_es_valid;
        if (ds_to_es_valid) begin
          fld_d.pc       = ds_pc;
          fld_d.aluop    = ds_aluop;
          fld_d.rs_val   = ds_rs_val;
          fld_d.rt_val   = ds_rt_val;
          fld_d.imm      = ds_imm;
          fld_d.sa       = ds_sa;
          fld_d.src1_sa  = ds_src1_sa;
          fld_d.src2_imm = ds_src2_imm;
          fld_d.imm_zext = ds_imm_zext;
          fld_d.ov_en    = ds_ov_en;
          fld_d.rf_we    = ds_rf_we;
          fld_d.dest     = ds_dest;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q   <= 1'b0;
      ex_pending_q <= 1'b0;
      fld_q        <= '0;
    end else begin
      es_valid_q   <= es_valid_d;
      ex_pending_q <= ex_pending_d;
      fld_q        <= fld_d;
    end
  end

endmodule

// File: tb/tb_exe_operand_stage.sv
// Directed bench for exe_operand_stage; the ALU is stood in for by driven aluso/overflow.
module tb_exe_operand_stage;

  localparam int DW  = 32;
  localparam int OPW = 12;
  localparam logic [OPW-1:0] OP_ADD = 12'h800;
  localparam logic [OPW-1:0] OP_OR  = 12'h100;
  localparam logic [OPW-1:0] OP_SLL = 12'h008;

  logic           clk = 1'b0;
  logic           reset, flush, ds_to_es_valid, es_allowin;
  logic [31:0]    ds_pc;
  logic [OPW-1:0] ds_aluop;
  logic [DW-1:0]  ds_rs_val, ds_rt_val;
  logic [15:0]    ds_imm;
  logic [4:0]     ds_sa, ds_dest;
  logic           ds_src1_sa, ds_src2_imm, ds_imm_zext, ds_ov_en, ds_rf_we;
  logic [DW-1:0]  alu_scr0, alu_scr1, alu_aluso;
  logic [OPW-1:0] alu_aluop;
  logic           alu_overflow, ms_allowin, es_to_ms_valid;
  logic [31:0]    es_pc;
  logic [DW-1:0]  es_result, es_fwd_data;
  logic [4:0]     es_dest, es_fwd_dest;
  logic           es_rf_we, es_ex_ov, es_fwd_we;

  int nchk  = 0;
  int nfail = 0;

  exe_operand_stage #(.DW(DW), .OPW(OPW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .ds_pc(ds_pc), .ds_aluop(ds_aluop), .ds_rs_val(ds_rs_val), .ds_rt_val(ds_rt_val),
    .ds_imm(ds_imm), .ds_sa(ds_sa), .ds_src1_sa(ds_src1_sa), .ds_src2_imm(ds_src2_imm),
    .ds_imm_zext(ds_imm_zext), .ds_ov_en(ds_ov_en), .ds_rf_we(ds_rf_we), .ds_dest(ds_dest),
    .alu_scr0(alu_scr0), .alu_scr1(alu_scr1), .alu_aluop(alu_aluop),
    .alu_aluso(alu_aluso), .alu_overflow(alu_overflow), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc), .es_result(es_result),
    .es_dest(es_dest), .es_rf_we(es_rf_we), .es_ex_ov(es_ex_ov),
    .es_fwd_we(es_fwd_we), .es_fwd_dest(es_fwd_dest), .es_fwd_data(es_fwd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [OPW-1:0] op,
                       input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                       input logic [15:0] imm, input logic [4:0] sa,
                       input logic s1sa, input logic s2imm, input logic zext,
                       input logic oven, input logic we, input logic [4:0] dest);
    ds_to_es_valid = 1'b1;
    ds_pc = pc; ds_aluop = op; ds_rs_val = rs; ds_rt_val = rt; ds_imm = imm; ds_sa = sa;
    ds_src1_sa = s1sa; ds_src2_imm = s2imm; ds_imm_zext = zext;
    ds_ov_en = oven; ds_rf_we = we; ds_dest = dest;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; ms_allowin = 1'b1;
    alu_aluso = '0; alu_overflow = 1'b0;
    drive(32'h0, '0, '0, '0, '0, '0, 0, 0, 0, 0, 0, '0);
    ds_to_es_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    nchk++; if (es_allowin !== 1'b1) begin nfail++; $display("FAIL reset_allowin got %b want 1", es_allowin); end
    nchk++; if (es_to_ms_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", es_to_ms_valid); end
    nchk++; if (alu_aluop !== '0) begin nfail++; $display("FAIL reset_aluop got %h want 0", alu_aluop); end
    nchk++; if (alu_scr0 !== '0 || alu_scr1 !== '0) begin nfail++; $display("FAIL reset_scr got %h/%h want 0/0", alu_scr0, alu_scr1); end
    nchk++; if (es_pc !== '0 || es_dest !== '0) begin nfail++; $display("FAIL reset_fields got pc=%h dest=%0d want 0/0", es_pc, es_dest); end
    nchk++; if (es_rf_we !== 1'b0 || es_ex_ov !== 1'b0 || es_fwd_we !== 1'b0) begin nfail++; $display("FAIL reset_flags got we=%b ov=%b fwd=%b want 0", es_rf_we, es_ex_ov, es_fwd_we); end
  endtask

  task automatic test_addiu();
    drive(32'h100, OP_ADD, 32'd5, 32'h1234, 16'hFFFF, 5'd0, 0, 1, 0, 0, 1, 5'd3);
    tick();
    ds_to_es_valid = 1'b0;
    alu_aluso = 32'd4;
    #1;
    nchk++; if (alu_scr0 !== 32'd5) begin nfail++; $display("FAIL addiu_scr0 got %h want 5", alu_scr0); end
    nchk++; if (alu_scr1 !== 32'hFFFFFFFF) begin nfail++; $display("FAIL addiu_scr1 got %h want ffffffff", alu_scr1); end
    nchk++; if (alu_aluop !== OP_ADD) begin nfail++; $display("FAIL addiu_aluop got %h want %h", alu_aluop, OP_ADD); end
    nchk++; if (es_result !== 32'd4 || es_fwd_data !== 32'd4) begin nfail++; $display("FAIL addiu_result got %h/%h want 4", es_result, es_fwd_data); end
    nchk++; if (es_rf_we !== 1'b1 || es_fwd_we !== 1'b1 || es_fwd_dest !== 5'd3) begin nfail++; $display("FAIL addiu_we got we=%b fwd=%b fd=%0d want 1/1/3", es_rf_we, es_fwd_we, es_fwd_dest); end
    nchk++; if (es_to_ms_valid !== 1'b1 || es_pc !== 32'h100 || es_dest !== 5'd3) begin nfail++; $display("FAIL addiu_out got v=%b pc=%h d=%0d want 1/100/3", es_to_ms_valid, es_pc, es_dest); end
    tick();
    nchk++; if (es_to_ms_valid !== 1'b0 || alu_aluop !== '0) begin nfail++; $display("FAIL addiu_drain got v=%b op=%h want 0/0", es_to_ms_valid, alu_aluop); end
  endtask

  task automatic test_ori_sll();
    drive(32'h104, OP_OR, 32'h0F0F0000, 32'h0, 16'h8000, 5'd0, 0, 1, 1, 0, 1, 5'd4);
    tick();
    drive(32'h108, OP_SLL, 32'h11111111, 32'hA5A50001, 16'h0, 5'd3, 1, 0, 0, 0, 1, 5'd5);
    #1;
    nchk++; if (alu_scr1 !== 32'h00008000) begin nfail++; $display("FAIL ori_scr1 got %h want 00008000", alu_scr1); end
    nchk++; if (alu_scr0 !== 32'h0F0F0000 || alu_aluop !== OP_OR) begin nfail++; $display("FAIL ori_scr0 got %h op=%h want 0f0f0000/%h", alu_scr0, alu_aluop, OP_OR); end
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    nchk++; if (alu_scr0 !== 32'd3) begin nfail++; $display("FAIL sll_scr0 got %h want 3", alu_scr0); end
    nchk++; if (alu_scr1 !== 32'hA5A50001 || alu_aluop !== OP_SLL) begin nfail++; $display("FAIL sll_scr1 got %h op=%h want a5a50001/%h", alu_scr1, alu_aluop, OP_SLL); end
    nchk++; if (es_pc !== 32'h108 || es_ex_ov !== 1'b0) begin nfail++; $display("FAIL sll_pc got %h ov=%b want 108/0", es_pc, es_ex_ov); end
    tick();
  endtask

  task automatic test_back_pressure();
    drive(32'h200, OP_ADD, 32'hCAFE0000, 32'h1, 16'h0, 5'd0, 0, 0, 0, 0, 1, 5'd6);
    tick();
    ms_allowin = 1'b0;
    drive(32'h204, OP_OR, 32'hBEEF0000, 32'h2, 16'h0, 5'd0, 0, 0, 0, 0, 1, 5'd7);
    #1;
    nchk++; if (es_allowin !== 1'b0) begin nfail++; $display("FAIL bp_allowin got %b want 0", es_allowin); end
    for (int i = 0; i < 3; i++) begin
      tick();
      nchk++; if (es_pc !== 32'h200 || alu_scr0 !== 32'hCAFE0000 || es_dest !== 5'd6 || alu_aluop !== OP_ADD) begin
        nfail++; $display("FAIL bp_hold%0d got pc=%h scr0=%h d=%0d op=%h want 200/cafe0000/6/%h", i, es_pc, alu_scr0, es_dest, alu_aluop, OP_ADD);
      end
      nchk++; if (es_to_ms_valid !== 1'b1 || es_allowin !== 1'b0) begin nfail++; $display("FAIL bp_hs%0d got v=%b a=%b want 1/0", i, es_to_ms_valid, es_allowin); end
    end
    ms_allowin = 1'b1;
    #1;
    nchk++; if (es_allowin !== 1'b1) begin nfail++; $display("FAIL bp_release got %b want 1", es_allowin); end
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    nchk++; if (es_pc !== 32'h204 || alu_scr0 !== 32'hBEEF0000 || es_dest !== 5'd7) begin nfail++; $display("FAIL bp_next got pc=%h scr0=%h d=%0d want 204/beef0000/7", es_pc, alu_scr0, es_dest); end
    tick();
  endtask

  task automatic test_overflow_flush();
    drive(32'h2C0, OP_ADD, 32'h7FFFFFFF, 32'h1, 16'h0, 5'd0, 0, 0, 0, 1, 1, 5'd2);
    tick();
    drive(32'h2C4, OP_ADD, 32'h3, 32'h2, 16'h0, 5'd0, 0, 0, 0, 0, 1, 5'd2);
    alu_aluso = 32'h80000000; alu_overflow = 1'b1;
    #1;
    nchk++; if (es_ex_ov !== 1'b1) begin nfail++; $display("FAIL ov_flag got %b want 1", es_ex_ov); end
    nchk++; if (es_rf_we !== 1'b0 || es_fwd_we !== 1'b0) begin nfail++; $display("FAIL ov_we got we=%b fwd=%b want 0/0", es_rf_we, es_fwd_we); end
    nchk++; if (alu_scr0 !== 32'h7FFFFFFF || alu_scr1 !== 32'h1) begin nfail++; $display("FAIL ov_scr got %h/%h want 7fffffff/1", alu_scr0, alu_scr1); end
    tick();
    ds_to_es_valid = 1'b0;
    alu_aluso = 32'd5; alu_overflow = 1'b0;
    #1;
    nchk++; if (es_to_ms_valid !== 1'b1 || es_pc !== 32'h2C4) begin nfail++; $display("FAIL pend_flow got v=%b pc=%h want 1/2c4", es_to_ms_valid, es_pc); end
    nchk++; if (es_rf_we !== 1'b0 || es_fwd_we !== 1'b0 || es_ex_ov !== 1'b0) begin nfail++; $display("FAIL pend_cancel got we=%b fwd=%b ov=%b want 0/0/0", es_rf_we, es_fwd_we, es_ex_ov); end
    ms_allowin = 1'b0;
    tick();
    ms_allowin = 1'b1;
    drive(32'h300, OP_OR, 32'h9, 32'h9, 16'h0, 5'd0, 0, 0, 0, 0, 1, 5'd9);
    flush = 1'b1;
    #1;
    nchk++; if (es_to_ms_valid !== 1'b0) begin nfail++; $display("FAIL flush_valid got %b want 0", es_to_ms_valid); end
    tick();
    flush = 1'b0; ds_to_es_valid = 1'b0;
    #1;
    nchk++; if (es_allowin !== 1'b1 || es_to_ms_valid !== 1'b0 || alu_aluop !== '0) begin nfail++; $display("FAIL flush_empty got a=%b v=%b op=%h want 1/0/0", es_allowin, es_to_ms_valid, alu_aluop); end
    nchk++; if (es_pc !== 32'h2C4) begin nfail++; $display("FAIL flush_drop got pc=%h want 2c4", es_pc); end
    drive(32'h304, OP_ADD, 32'h1, 32'h1, 16'h0, 5'd0, 0, 0, 0, 0, 1, 5'd4);
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    nchk++; if (es_rf_we !== 1'b1 || es_fwd_we !== 1'b1 || es_fwd_dest !== 5'd4) begin nfail++; $display("FAIL flush_clear got we=%b fwd=%b fd=%0d want 1/1/4", es_rf_we, es_fwd_we, es_fwd_dest); end
    tick();
  endtask

  task automatic test_dest0_reset();
    drive(32'h400, OP_ADD, 32'h1, 32'h1, 16'h0, 5'd0, 0, 0, 0, 0, 1, 5'd0);
    tick();
    #1;
    nchk++; if (es_rf_we !== 1'b1 || es_fwd_we !== 1'b0) begin nfail++; $display("FAIL dest0 got we=%b fwd=%b want 1/0", es_rf_we, es_fwd_we); end
    ms_allowin = 1'b0;
    drive(32'h404, OP_OR, 32'h1, 32'h1, 16'h0, 5'd0, 0, 0, 0, 0, 1, 5'd8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    nchk++; if (es_allowin !== 1'b1 || es_to_ms_valid !== 1'b0) begin nfail++; $display("FAIL midreset got a=%b v=%b want 1/0", es_allowin, es_to_ms_valid); end
    nchk++; if (es_pc !== 32'h0 || es_dest !== 5'd0) begin nfail++; $display("FAIL midreset_fields got pc=%h d=%0d want 0/0", es_pc, es_dest); end
    ds_to_es_valid = 1'b0; ms_allowin = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_addiu();
    test_ori_sll();
    test_back_pressure();
    test_overflow_flush();
    test_dest0_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
